// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner with press/release debounce and
// 4-bit key encoding for the calculator input path.
module keypad_encoder #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_HELD,
    S_REL
  } state_t;

  state_t        r_state;
  state_t        w_state;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [1:0]    r_col;
  logic [1:0]    w_col;
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] w_dwell;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic [1:0]    r_row;
  logic [1:0]    w_row;
  logic [3:0]    r_code;
  logic [3:0]    w_code;
  logic          r_valid;
  logic          w_valid;
  logic [1:0]    w_low_row;
  logic          w_hit;

  function automatic logic [3:0] f_map(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] v;
    unique case ({r, c})
      4'h0: v = 4'd1;
      4'h1: v = 4'd2;
      4'h2: v = 4'd3;
      4'h3: v = 4'd10;
      4'h4: v = 4'd4;
      4'h5: v = 4'd5;
      4'h6: v = 4'd6;
      4'h7: v = 4'd11;
      4'h8: v = 4'd7;
      4'h9: v = 4'd8;
      4'hA: v = 4'd9;
      4'hB: v = 4'd12;
      4'hC: v = 4'd14;
      4'hD: v = 4'd0;
      4'hE: v = 4'd15;
      4'hF: v = 4'd13;
    endcase
    return v;
  endfunction

  // lowest-index low row wins when several rows are closed
  always_comb begin
    w_low_row = 2'd3;
    if (!r_s2[0])      w_low_row = 2'd0;
    else if (!r_s2[1]) w_low_row = 2'd1;
    else if (!r_s2[2]) w_low_row = 2'd2;
  end

  assign w_hit = ~r_s2[r_row];

  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_dwell = r_dwell;
    w_cnt   = r_cnt;
    w_row   = r_row;
    w_code  = r_code;
    w_valid = 1'b0;
    unique case (r_state)
      S_SCAN: begin
        if (r_dwell == DWELL_MAX) begin
          w_dwell = '0;
          if (r_s2 != 4'b1111) begin
            w_row   = w_low_row;
            w_cnt   = CNT_ONE;
            w_state = S_DEB;
          end else begin
            w_col = r_col + 2'd1;
          end
        end else begin
          w_dwell = r_dwell + 1'b1;
        end
      end
      S_DEB: begin
        if (w_hit) begin
          if (r_cnt == CNT_MAX) begin
            w_code  = f_map(r_row, r_col);
            w_valid = 1'b1;
            w_cnt   = '0;
            w_state = S_HELD;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end else begin
          w_cnt   = '0;
          w_dwell = '0;
          w_col   = r_col + 2'd1;
          w_state = S_SCAN;
        end
      end
      S_HELD: begin
        if (!w_hit) begin
          w_cnt   = CNT_ONE;
          w_state = S_REL;
        end
      end
      S_REL: begin
        if (w_hit) begin
          w_cnt   = '0;
          w_state = S_HELD;
        end else if (r_cnt == CNT_MAX) begin
          w_cnt   = '0;
          w_dwell = '0;
          w_col   = r_col + 2'd1;
          w_state = S_SCAN;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = S_SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_SCAN;
      r_s1    <= 4'b1111;
      r_s2    <= 4'b1111;
      r_col   <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_row   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_s1    <= row_in;
      r_s2    <= r_s1;
      r_col   <= w_col;
      r_dwell <= w_dwell;
      r_cnt   <= w_cnt;
      r_row   <= w_row;
      r_code  <= w_code;
      r_valid <= w_valid;
    end
  end

  assign col_out   = ~(4'b0001 << r_col);
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = (r_state == S_HELD) || (r_state == S_REL);

endmodule
